// File: rtl/microroc_readout_emulator.sv
// microroc_readout_emulator
//
// Transmitter-side emulator of the Microroc digital RAM readout port. Hit events
// are buffered from a valid/ready source. Each start_readout rising edge sends the
// whole buffer serially on active-low dout_b/transmiton_b, then pulses end_readout.
//
// Frame: 160 bits, MSB first = {CHIP_ID[7:0], ev_bcid[23:0], ev_hits[127:0]}.
// Each bit is held for BIT_CLKS cycles. Consecutive events in one transfer are
// separated by GAP_CLKS idle cycles. During the gap, transmiton_b stays low and
// dout_b stays high.
//
// Build option:
//   MICROROC_EMU_LIFO_EN  defined   -> events are read newest first (real ASIC RAM order)
//                         undefined -> events are read oldest first (FIFO)
//
// Ports:
//   Clk            system clock (40 MHz)
//   reset          asynchronous reset, active-high
//   ev_valid       event present on ev_bcid/ev_hits
//   ev_ready       event accepted on ev_valid & ev_ready at a rising Clk edge
//   ev_bcid        event BCID (24 bits)
//   ev_hits        64 channels x 2 discriminator bits (128 bits)
//   start_readout  readout request, acted on at a rising edge while idle
//   end_readout    one-cycle pulse when a readout finishes
//   dout_b         serial data, active-low
//   transmiton_b   low while a transfer is in progress
//   chipsat_b      low while the event memory is full

module microroc_readout_emulator #(
  parameter int unsigned BIT_CLKS = 8,
  parameter int unsigned GAP_CLKS = 16,
  parameter int unsigned DEPTH    = 4,
  parameter logic [7:0]  CHIP_ID  = 8'hA1
) (
  input  logic         Clk,
  input  logic         reset,
  input  logic         ev_valid,
  output logic         ev_ready,
  input  logic [23:0]  ev_bcid,
  input  logic [127:0] ev_hits,
  input  logic         start_readout,
  output logic         end_readout,
  output logic         dout_b,
  output logic         transmiton_b,
  output logic         chipsat_b
);

  localparam int unsigned FrameBits = 160;
  localparam int unsigned EvBits    = 152;
  localparam int unsigned PtrW      = $clog2(DEPTH);
  localparam int unsigned CntW      = PtrW + 1;
  localparam int unsigned DivW      = $clog2(BIT_CLKS);
  localparam int unsigned GapW      = $clog2(GAP_CLKS + 1);

  localparam logic [7:0]      LastBit  = 8'd159;
  localparam logic [DivW-1:0] DivLast  = DivW'(BIT_CLKS - 1);
  localparam logic [GapW-1:0] GapLast  = GapW'(GAP_CLKS - 1);
  localparam logic [CntW-1:0] CntFull  = CntW'(DEPTH);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StShift,
    StGap,
    StEnd
  } state_e;

  state_e                 state_q, state_d;
  logic [CntW-1:0]        count_q, count_d;
  logic [PtrW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [FrameBits-1:0]   shreg_q, shreg_d;
  logic [7:0]             bit_q, bit_d;
  logic [DivW-1:0]        div_q, div_d;
  logic [GapW-1:0]        gap_q, gap_d;
  logic                   sync_q, prev_q;
  logic                   ev_ready_q, chipsat_q;

  logic [EvBits-1:0]      mem [DEPTH];
  logic [PtrW-1:0]        rd_idx;
  logic [EvBits-1:0]      mem_rd;
  logic                   push, pop, start_edge;

`ifdef MICROROC_EMU_LIFO_EN
  // Newest entry sits just below the write pointer; popping walks it back down.
  assign rd_idx = wr_ptr_q - 1'b1;
`else
  logic [PtrW-1:0]        rd_ptr_q, rd_ptr_d;
  assign rd_idx = rd_ptr_q;
`endif

  assign mem_rd     = mem[rd_idx];
  assign push       = ev_valid & ev_ready_q;
  assign start_edge = sync_q & ~prev_q;
  assign ev_ready   = ev_ready_q;
  assign chipsat_b  = chipsat_q;

  // Event storage carries no reset; only the pointers and the count define its contents.
  always_ff @(posedge Clk) begin
    if (push) begin
      mem[wr_ptr_q] <= {ev_bcid, ev_hits};
    end
  end

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    wr_ptr_d     = wr_ptr_q;
`ifndef MICROROC_EMU_LIFO_EN
    rd_ptr_d     = rd_ptr_q;
`endif
    shreg_d      = shreg_q;
    bit_d        = bit_q;
    div_d        = div_q;
    gap_d        = gap_q;
    pop          = 1'b0;
    end_readout  = 1'b0;
    dout_b       = 1'b1;
    transmiton_b = 1'b1;

    unique case (state_q)
      StIdle: begin
        if (start_edge) begin
          state_d = StLoad;
        end
      end

      // The empty case also passes through here. Both outcomes are then decided one cycle
      // after the start edge, so end_readout lands on cycle 2 of an empty readout.
      StLoad: begin
        if (count_q == '0) begin
          state_d = StEnd;
        end else begin
          pop     = 1'b1;
          bit_d   = '0;
          div_d   = '0;
          state_d = StShift;
        end
      end

      StShift: begin
        transmiton_b = 1'b0;
        dout_b       = ~shreg_q[FrameBits-1];
        if (div_q == DivLast) begin
          div_d = '0;
          if (bit_q == LastBit) begin
            gap_d   = '0;
            state_d = (count_q != '0) ? StGap : StEnd;
          end else begin
            bit_d   = bit_q + 8'd1;
            shreg_d = {shreg_q[FrameBits-2:0], 1'b0};
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      StGap: begin
        transmiton_b = 1'b0;
        if (gap_q == GapLast) begin
          // Load on the last gap cycle, so the first bit starts exactly after GAP_CLKS.
          pop     = 1'b1;
          bit_d   = '0;
          div_d   = '0;
          state_d = StShift;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end

      StEnd: begin
        end_readout = 1'b1;
        state_d     = StIdle;
      end

      default: state_d = StIdle;
    endcase

    if (pop) begin
      shreg_d = {CHIP_ID, mem_rd};
      count_d = count_q - 1'b1;
`ifdef MICROROC_EMU_LIFO_EN
      wr_ptr_d = wr_ptr_q - 1'b1;
`else
      rd_ptr_d = rd_ptr_q + 1'b1;
`endif
    end

    // Pushes are only accepted in idle, so they never meet a pop.
    if (push) begin
      count_d  = count_q + 1'b1;
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      count_q    <= '0;
      wr_ptr_q   <= '0;
`ifndef MICROROC_EMU_LIFO_EN
      rd_ptr_q   <= '0;
`endif
      shreg_q    <= '0;
      bit_q      <= '0;
      div_q      <= '0;
      gap_q      <= '0;
      sync_q     <= 1'b0;
      prev_q     <= 1'b0;
      ev_ready_q <= 1'b0;
      chipsat_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
`ifndef MICROROC_EMU_LIFO_EN
      rd_ptr_q   <= rd_ptr_d;
`endif
      shreg_q    <= shreg_d;
      bit_q      <= bit_d;
      div_q      <= div_d;
      gap_q      <= gap_d;
      sync_q     <= start_readout;
      prev_q     <= sync_q;
      // Registered from next-state values so both flags track state/count without lag.
      ev_ready_q <= (state_d == StIdle) && (count_d < CntFull);
      chipsat_q  <= ~(count_d == CntFull);
    end
  end

endmodule
